// File: rtl/issue_queue.sv
// Compacting out-of-order issue queue: oldest entry at slot 0, tag wakeup,
// and combinational oldest-ready selection.
module issue_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TAGW  = 6
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    flush,
  input  logic                    dispatch_valid,
  output logic                    dispatch_ready,
  input  logic [TAGW-1:0]         dispatch_rob_idx,
  input  logic [TAGW-1:0]         dispatch_phys_rd,
  input  logic [TAGW-1:0]         dispatch_phys_rs1,
  input  logic [TAGW-1:0]         dispatch_phys_rs2,
  input  logic                    dispatch_rs1_ready,
  input  logic                    dispatch_rs2_ready,
  input  logic [31:0]             dispatch_instr,
  input  logic                    wakeup_valid,
  input  logic [TAGW-1:0]         wakeup_tag,
  output logic                    issue_valid,
  input  logic                    issue_ready,
  output logic [TAGW-1:0]         issue_rob_idx,
  output logic [TAGW-1:0]         issue_phys_rd,
  output logic [TAGW-1:0]         issue_phys_rs1,
  output logic [TAGW-1:0]         issue_phys_rs2,
  output logic [31:0]             issue_instr,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = IW + 1;

  typedef struct packed {
    logic            rdy1;
    logic            rdy2;
    logic [TAGW-1:0] rob;
    logic [TAGW-1:0] rd;
    logic [TAGW-1:0] rs1;
    logic [TAGW-1:0] rs2;
    logic [31:0]     instr;
  } entry_t;

  entry_t          r_q [DEPTH];
  logic [CW-1:0]   r_count;

  entry_t          w_wk [DEPTH];
  entry_t          w_nq [DEPTH];
  entry_t          w_new;
  logic [DEPTH-1:0] w_elig;
  logic            w_found;
  logic [IW-1:0]   w_sel;
  logic            w_issue_fire;
  logic            w_disp_fire;
  logic [CW-1:0]   w_base;
  logic [CW-1:0]   w_ncount;

  assign dispatch_ready = (r_count < CW'(DEPTH));
  assign occupancy      = r_count;

  // Eligibility uses registered ready bits only; descending scan leaves the oldest.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_elig[i] = (CW'(i) < r_count) && r_q[i].rdy1 && r_q[i].rdy2;
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_found = 1'b1;
        w_sel   = IW'(i);
      end
    end
  end

  always_comb begin
    issue_valid    = w_found;
    issue_rob_idx  = '0;
    issue_phys_rd  = '0;
    issue_phys_rs1 = '0;
    issue_phys_rs2 = '0;
    issue_instr    = '0;
    if (w_found) begin
      issue_rob_idx  = r_q[w_sel].rob;
      issue_phys_rd  = r_q[w_sel].rd;
      issue_phys_rs1 = r_q[w_sel].rs1;
      issue_phys_rs2 = r_q[w_sel].rs2;
      issue_instr    = r_q[w_sel].instr;
    end
  end

  // Next queue image: wakeup, then compaction over the issued slot, then append.
  always_comb begin
    w_issue_fire = w_found && issue_ready;
    w_disp_fire  = dispatch_valid && dispatch_ready;

    w_new.rob   = dispatch_rob_idx;
    w_new.rd    = dispatch_phys_rd;
    w_new.rs1   = dispatch_phys_rs1;
    w_new.rs2   = dispatch_phys_rs2;
    w_new.instr = dispatch_instr;
    w_new.rdy1  = dispatch_rs1_ready || (dispatch_phys_rs1 == '0) ||
                  (wakeup_valid && (dispatch_phys_rs1 == wakeup_tag));
    w_new.rdy2  = dispatch_rs2_ready || (dispatch_phys_rs2 == '0) ||
                  (wakeup_valid && (dispatch_phys_rs2 == wakeup_tag));

    for (int i = 0; i < DEPTH; i++) begin
      w_wk[i] = r_q[i];
      if (wakeup_valid && (r_q[i].rs1 == wakeup_tag)) w_wk[i].rdy1 = 1'b1;
      if (wakeup_valid && (r_q[i].rs2 == wakeup_tag)) w_wk[i].rdy2 = 1'b1;
    end

    for (int i = 0; i < DEPTH - 1; i++) begin
      w_nq[i] = (w_issue_fire && (IW'(i) >= w_sel)) ? w_wk[i+1] : w_wk[i];
    end
    w_nq[DEPTH-1] = w_wk[DEPTH-1];

    w_base = r_count - CW'(w_issue_fire);
    if (w_disp_fire) w_nq[w_base[IW-1:0]] = w_new;
    w_ncount = w_base + CW'(w_disp_fire);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else begin
      r_count <= w_ncount;
      for (int i = 0; i < DEPTH; i++) r_q[i] <= w_nq[i];
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Directed self-checking bench for issue_queue (DEPTH 8, TAGW 6).
module tb_issue_queue;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        dispatch_valid;
  logic        dispatch_ready;
  logic [5:0]  dispatch_rob_idx;
  logic [5:0]  dispatch_phys_rd;
  logic [5:0]  dispatch_phys_rs1;
  logic [5:0]  dispatch_phys_rs2;
  logic        dispatch_rs1_ready;
  logic        dispatch_rs2_ready;
  logic [31:0] dispatch_instr;
  logic        wakeup_valid;
  logic [5:0]  wakeup_tag;
  logic        issue_valid;
  logic        issue_ready;
  logic [5:0]  issue_rob_idx;
  logic [5:0]  issue_phys_rd;
  logic [5:0]  issue_phys_rs1;
  logic [5:0]  issue_phys_rs2;
  logic [31:0] issue_instr;
  logic [3:0]  occupancy;

  int n_checks = 0;
  int n_errors = 0;

  issue_queue #(.DEPTH(8), .TAGW(6)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .flush              (flush),
    .dispatch_valid     (dispatch_valid),
    .dispatch_ready     (dispatch_ready),
    .dispatch_rob_idx   (dispatch_rob_idx),
    .dispatch_phys_rd   (dispatch_phys_rd),
    .dispatch_phys_rs1  (dispatch_phys_rs1),
    .dispatch_phys_rs2  (dispatch_phys_rs2),
    .dispatch_rs1_ready (dispatch_rs1_ready),
    .dispatch_rs2_ready (dispatch_rs2_ready),
    .dispatch_instr     (dispatch_instr),
    .wakeup_valid       (wakeup_valid),
    .wakeup_tag         (wakeup_tag),
    .issue_valid        (issue_valid),
    .issue_ready        (issue_ready),
    .issue_rob_idx      (issue_rob_idx),
    .issue_phys_rd      (issue_phys_rd),
    .issue_phys_rs1     (issue_phys_rs1),
    .issue_phys_rs2     (issue_phys_rs2),
    .issue_instr        (issue_instr),
    .occupancy          (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dispatch_valid = 1'b0;
    wakeup_valid   = 1'b0;
    issue_ready    = 1'b0;
    flush          = 1'b0;
  endtask

  // rd and instr are derived from rob so payload routing can be checked.
  task automatic disp(input logic [5:0] rob, input logic [5:0] rs1, input logic [5:0] rs2,
                      input logic r1, input logic r2);
    dispatch_valid     = 1'b1;
    dispatch_rob_idx   = rob;
    dispatch_phys_rd   = rob + 6'd32;
    dispatch_phys_rs1  = rs1;
    dispatch_phys_rs2  = rs2;
    dispatch_rs1_ready = r1;
    dispatch_rs2_ready = r2;
    dispatch_instr     = 32'hA000_0000 | {26'd0, rob};
  endtask

  task automatic wake(input logic [5:0] tag);
    wakeup_valid = 1'b1;
    wakeup_tag   = tag;
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    dispatch_rob_idx = '0; dispatch_phys_rd = '0; dispatch_phys_rs1 = '0;
    dispatch_phys_rs2 = '0; dispatch_rs1_ready = 1'b0; dispatch_rs2_ready = 1'b0;
    dispatch_instr = '0; wakeup_tag = '0;
    #2;
    check("rst_occ", 64'(occupancy), 64'd0);
    check("rst_dready", 64'(dispatch_ready), 64'd1);
    check("rst_ivalid", 64'(issue_valid), 64'd0);
    check("rst_irob", 64'(issue_rob_idx), 64'd0);
    check("rst_iinstr", 64'(issue_instr), 64'd0);

    // Older entry blocked on rs1, younger one ready: younger issues first.
    @(negedge clk);
    reset_n = 1'b1;
    disp(6'd0, 6'd5, 6'd0, 1'b0, 1'b0);
    cyc();
    check("t37_occ1", 64'(occupancy), 64'd1);
    check("t37_blocked", 64'(issue_valid), 64'd0);
    disp(6'd1, 6'd7, 6'd8, 1'b1, 1'b1);
    cyc(); idle();
    check("t37_ivalid", 64'(issue_valid), 64'd1);
    check("t37_irob", 64'(issue_rob_idx), 64'd1);
    check("t37_ird", 64'(issue_phys_rd), 64'd33);
    check("t37_occ2", 64'(occupancy), 64'd2);
    issue_ready = 1'b1;
    cyc(); idle();
    check("t37_occ_after", 64'(occupancy), 64'd1);
    check("t37_rob0_waits", 64'(issue_valid), 64'd0);

    // Wakeup becomes visible only after the edge that captures it.
    disp(6'd2, 6'd12, 6'd0, 1'b0, 1'b0);
    cyc(); idle();
    check("t38_occ", 64'(occupancy), 64'd2);
    check("t38_wait", 64'(issue_valid), 64'd0);
    wake(6'd12);
    #1;
    check("t38_not_early", 64'(issue_valid), 64'd0);
    cyc(); idle();
    check("t38_ivalid", 64'(issue_valid), 64'd1);
    check("t38_irob", 64'(issue_rob_idx), 64'd2);
    issue_ready = 1'b1;
    cyc(); idle();
    check("t38_occ_after", 64'(occupancy), 64'd1);
    wake(6'd5);
    cyc(); idle();
    check("t38_rob0_ivalid", 64'(issue_valid), 64'd1);
    check("t38_rob0_irob", 64'(issue_rob_idx), 64'd0);
    check("t38_rob0_rs1", 64'(issue_phys_rs1), 64'd5);
    issue_ready = 1'b1;
    cyc(); idle();
    check("t38_empty_occ", 64'(occupancy), 64'd0);
    check("t38_empty_iv", 64'(issue_valid), 64'd0);

    // In-order drain of three ready entries; no bypass from an empty queue.
    disp(6'd3, 6'd0, 6'd0, 1'b0, 1'b0);
    #1;
    check("t33_no_bypass", 64'(issue_valid), 64'd0);
    cyc();
    disp(6'd4, 6'd0, 6'd0, 1'b0, 1'b0);
    cyc();
    disp(6'd5, 6'd0, 6'd0, 1'b0, 1'b0);
    cyc(); idle();
    check("t40_occ3", 64'(occupancy), 64'd3);
    issue_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("t40_irob", 64'(issue_rob_idx), 64'(3 + k));
      check("t40_occ", 64'(occupancy), 64'(3 - k));
      cyc();
    end
    idle();
    check("t40_occ0", 64'(occupancy), 64'd0);
    check("t40_iv0", 64'(issue_valid), 64'd0);

    // Same-cycle dispatch and wakeup of the dispatched source.
    disp(6'd6, 6'd9, 6'd0, 1'b0, 1'b0);
    wake(6'd9);
    cyc(); idle();
    check("t41_ivalid", 64'(issue_valid), 64'd1);
    check("t41_irob", 64'(issue_rob_idx), 64'd6);
    check("t41_instr", 64'(issue_instr), 64'hA000_0006);
    issue_ready = 1'b1;
    disp(6'd7, 6'd20, 6'd0, 1'b0, 1'b0);
    cyc(); idle();
    check("t31_occ_same", 64'(occupancy), 64'd1);
    check("t31_iv", 64'(issue_valid), 64'd0);

    // Fill to DEPTH, reject the ninth, then free one slot.
    for (int k = 0; k < 7; k++) begin
      disp(6'(8 + k), 6'd30, 6'd0, 1'b0, 1'b0);
      cyc();
    end
    idle();
    check("t39_full_occ", 64'(occupancy), 64'd8);
    check("t39_full_dready", 64'(dispatch_ready), 64'd0);
    disp(6'd15, 6'd0, 6'd0, 1'b1, 1'b1);
    cyc(); idle();
    check("t39_reject_occ", 64'(occupancy), 64'd8);
    wake(6'd20);
    cyc(); idle();
    check("t39_iv", 64'(issue_valid), 64'd1);
    check("t39_irob", 64'(issue_rob_idx), 64'd7);
    issue_ready = 1'b1;
    disp(6'd15, 6'd0, 6'd0, 1'b1, 1'b1);
    #1;
    check("t22_dready_indep", 64'(dispatch_ready), 64'd0);
    cyc(); idle();
    check("t39_occ7", 64'(occupancy), 64'd7);
    check("t39_dready", 64'(dispatch_ready), 64'd1);
    check("t39_iv0", 64'(issue_valid), 64'd0);
    wake(6'd30);
    cyc(); idle();
    issue_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      check("t34_drain_rob", 64'(issue_rob_idx), 64'(8 + k));
      cyc();
    end
    idle();
    check("t39_drained_occ", 64'(occupancy), 64'd0);
    check("t39_drained_iv", 64'(issue_valid), 64'd0);

    // Flush overrides dispatch, issue and wakeup in the same cycle.
    for (int k = 0; k < 5; k++) begin
      disp(6'(16 + k), 6'd40, 6'd0, 1'b0, 1'b0);
      cyc();
    end
    idle();
    check("t42_occ5", 64'(occupancy), 64'd5);
    flush = 1'b1;
    disp(6'd21, 6'd0, 6'd0, 1'b1, 1'b1);
    wake(6'd40);
    issue_ready = 1'b1;
    cyc(); idle();
    check("t42_flush_occ", 64'(occupancy), 64'd0);
    check("t42_flush_iv", 64'(issue_valid), 64'd0);

    // Asynchronous reset mid-run, then first dispatch right after release.
    disp(6'd22, 6'd0, 6'd0, 1'b1, 1'b1);
    cyc();
    disp(6'd23, 6'd0, 6'd0, 1'b1, 1'b1);
    cyc(); idle();
    check("t42_pre_occ", 64'(occupancy), 64'd2);
    check("t42_pre_irob", 64'(issue_rob_idx), 64'd22);
    #3;
    reset_n = 1'b0;
    #1;
    check("t42_arst_occ", 64'(occupancy), 64'd0);
    check("t42_arst_iv", 64'(issue_valid), 64'd0);
    check("t42_arst_dready", 64'(dispatch_ready), 64'd1);
    check("t42_arst_irob", 64'(issue_rob_idx), 64'd0);
    check("t42_arst_instr", 64'(issue_instr), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    disp(6'd24, 6'd0, 6'd0, 1'b1, 1'b1);
    cyc(); idle();
    check("t36_first_occ", 64'(occupancy), 64'd1);
    check("t36_first_irob", 64'(issue_rob_idx), 64'd24);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 Parameter: DEPTH, 8, number of queue entries (power of two, 2..16).
REQ-003 Parameter: TAGW, 6, physical-register tag and ROB index width.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 flush  in  1  synchronous clear of all entries.
REQ-007 dispatch_valid  in  1  rename stage presents an instruction.
REQ-008 dispatch_ready  out  1  queue accepts the instruction this cycle.
REQ-009 dispatch_rob_idx  in  TAGW  ROB slot of the instruction.
REQ-010 dispatch_phys_rd  in  TAGW  renamed destination.
REQ-011 dispatch_phys_rs1 / dispatch_phys_rs2  in  TAGW each  renamed sources.
REQ-012 dispatch_rs1_ready / dispatch_rs2_ready  in  1 each  source value already produced.
REQ-013 dispatch_instr  in  32  opaque instruction payload.
REQ-014 wakeup_valid  in  1  writeback broadcast present.
REQ-015 wakeup_tag  in  TAGW  physical register just written.
REQ-016 issue_valid  out  1  an entry is selected for execution.
REQ-017 issue_ready  in  1  execution unit accepts the selected entry.
REQ-018 issue_rob_idx, issue_phys_rd, issue_phys_rs1, issue_phys_rs2  out  TAGW each  selected entry fields.
REQ-019 issue_instr  out  32  selected entry payload.
REQ-020 occupancy  out  log2(DEPTH)+1  number of valid entries.

Function
REQ-021 Storage SHALL be a compacting queue: slot 0 oldest, valid entries contiguous from slot 0.
REQ-022 dispatch_ready SHALL equal (occupancy < DEPTH) and SHALL NOT depend on same-cycle issue.
REQ-023 dispatch_valid && dispatch_ready at a rising edge SHALL write the entry to the first free slot after any same-cycle removal/compaction.
REQ-024 A source with tag 0 SHALL be stored ready regardless of its ready input.
REQ-025 A dispatched source whose tag equals wakeup_tag while wakeup_valid is high in the same cycle SHALL be stored ready.
REQ-026 At each rising edge with wakeup_valid, every valid entry source matching wakeup_tag SHALL set its ready bit.
REQ-027 An entry SHALL be eligible only when both ready bits are set in registered state; wakeup makes an entry eligible no earlier than the following cycle.
REQ-028 Selection SHALL be combinational: issue_valid high iff any eligible entry exists; issue_* outputs SHALL show the lowest-numbered (oldest) eligible slot.
REQ-029 When issue_valid is low, issue_* data outputs SHALL be 0.
REQ-030 issue_valid && issue_ready at a rising edge SHALL remove the selected entry and shift all higher slots down by one.
REQ-031 Dispatch and issue in the same cycle SHALL leave occupancy unchanged; dispatch alone +1; issue alone -1.
REQ-032 flush at a rising edge SHALL invalidate all entries, ignore same-cycle dispatch, issue, and wakeup; occupancy SHALL be 0 the next cycle.
REQ-033 With occupancy 0, issue_valid SHALL be 0 even if a same-cycle dispatch has both sources ready (no bypass).
REQ-034 Duplicate tags across entries SHALL be allowed; one wakeup SHALL set all matches.

Reset
REQ-035 While reset_n is low, all entries SHALL be invalid, occupancy 0, dispatch_ready 1, issue_valid 0, all issue_* data 0.
REQ-036 Reset assertion mid-operation SHALL take effect immediately without a clock edge; the first dispatch is accepted on the first rising edge after reset_n rises.

Verification
REQ-037 Dispatch rob 0 (rs1=5 not ready, rs2=0) then rob 1 (both ready) -> issue_valid next cycle with issue_rob_idx 1; rob 0 remains, occupancy 1.
REQ-038 Entry waiting on tag 12; wakeup_valid with tag 12 at edge N -> issue_valid first asserted after edge N with that entry selected.
REQ-039 Dispatch 8 entries with issue_ready 0 -> occupancy 8, dispatch_ready 0; 9th dispatch is not stored; one issue -> dispatch_ready 1 the next cycle.
REQ-040 Three eligible entries rob 3, 4, 5 with issue_ready held 1 -> issued in order 3, 4, 5 on consecutive cycles, occupancy 3->2->1->0.
REQ-041 Dispatch rs1 tag 9 not ready in the same cycle as wakeup of tag 9 -> entry stored ready and issued the following cycle.
REQ-042 Flush with occupancy 5 and simultaneous dispatch -> occupancy 0, issue_valid 0 next cycle; reset_n pulsed low mid-run -> outputs at reset values immediately.
